// File: rtl/tp_mem_arb_pkg.sv
// tp_mem_arb_pkg: shared widths, client-id sizing and the return-pipeline entry type
package tp_mem_arb_pkg;
    localparam int AW = 10;
    localparam int DW = 64;

    function automatic int clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Wide enough for the largest supported client count (4)
    localparam int IDW = clog2(4);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } ret_t;
endpackage

// File: rtl/tp_mem_arbiter_rr.sv
// rr_arbiter: round-robin pick starting at ptr; idx is the candidate, gnt/any only when en
module rr_arbiter
    import tp_mem_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic          found;
    logic [IW-1:0] j;

    // First requester at or after ptr, wrapping modulo N
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = IW'((int'(ptr) + i) % N);
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

    assign any = found && en;
    assign gnt = any ? (N'(1) << idx) : '0;
endmodule

// File: rtl/tp_mem_arbiter.sv
// tp_mem_arbiter: round-robin read/write port sharing for a two-port memory with collision deferral
module tp_mem_arbiter #(
    parameter int AW     = tp_mem_arb_pkg::AW,
    parameter int DW     = tp_mem_arb_pkg::DW,
    parameter int N_RD   = 2,
    parameter int N_WR   = 2,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_RD-1:0]    rd_req,
    input  logic [N_RD*AW-1:0] rd_addr,
    output logic [N_RD-1:0]    rd_gnt,
    output logic [N_RD-1:0]    rd_vld,
    output logic [DW-1:0]      rd_data,
    input  logic [N_WR-1:0]    wr_req,
    input  logic [N_WR*AW-1:0] wr_addr,
    input  logic [N_WR*DW-1:0] wr_data,
    output logic [N_WR-1:0]    wr_gnt,
    output logic               mem_rd_en,
    output logic [AW-1:0]      mem_rd_addr,
    input  logic [DW-1:0]      mem_rd_word,
    output logic               mem_wr_en,
    output logic [AW-1:0]      mem_wr_addr,
    output logic [DW-1:0]      mem_wr_word,
    output logic [15:0]        coll_cnt
);
    import tp_mem_arb_pkg::*;

    localparam int IWR = clog2(N_RD);
    localparam int IWW = clog2(N_WR);

    logic [IWR-1:0] rd_ptr, rd_c;
    logic [IWW-1:0] wr_ptr, wr_k;
    logic           rd_any, wr_any, coll;
    logic [AW-1:0]  rd_cand_addr;
    ret_t           pipe [RD_LAT];
    ret_t           ret;

    rr_arbiter #(.N(N_WR)) u_wr_arb (
        .req (wr_req),
        .ptr (wr_ptr),
        .en  (rst_n),
        .gnt (wr_gnt),
        .idx (wr_k),
        .any (wr_any)
    );

    assign mem_wr_en   = wr_any;
    assign mem_wr_addr = wr_addr[wr_k*AW +: AW];
    assign mem_wr_word = wr_data[wr_k*DW +: DW];

    // A read candidate hitting the address being written waits a cycle, so it sees the new data
    assign rd_cand_addr = rd_addr[rd_c*AW +: AW];
    assign coll         = wr_any && (|rd_req) && (rd_cand_addr == mem_wr_addr);

    rr_arbiter #(.N(N_RD)) u_rd_arb (
        .req (rd_req),
        .ptr (rd_ptr),
        .en  (rst_n && !coll),
        .gnt (rd_gnt),
        .idx (rd_c),
        .any (rd_any)
    );

    assign mem_rd_en   = rd_any;
    assign mem_rd_addr = rd_cand_addr;

    // Advance each pointer past the client just granted; count deferred reads, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            coll_cnt <= '0;
        end else begin
            if (rd_any) rd_ptr <= IWR'((int'(rd_c) + 1) % N_RD);
            if (wr_any) wr_ptr <= IWW'((int'(wr_k) + 1) % N_WR);
            if (coll && coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 16'd1;
        end
    end

    // Return pipeline tracking which client owns the word the memory delivers RD_LAT cycles later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {rd_any, IDW'(rd_c)};
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign ret     = pipe[RD_LAT-1];
    assign rd_vld  = ret.vld ? (N_RD'(1) << ret.id) : '0;
    assign rd_data = mem_rd_word;
endmodule

// File: tb/tb_tp_mem_arbiter.sv
// tb_tp_mem_arbiter: scoreboard bench with a reference memory and round-robin model
module tb_tp_mem_arbiter;
    localparam int AW = 10, DW = 64, N_RD = 2, N_WR = 2, RD_LAT = 1;

    logic clk = 0, rst_n = 0;
    logic [N_RD-1:0]    rd_req = '0;
    logic [N_RD*AW-1:0] rd_addr = '0;
    logic [N_RD-1:0]    rd_gnt, rd_vld;
    logic [DW-1:0]      rd_data;
    logic [N_WR-1:0]    wr_req = '0;
    logic [N_WR*AW-1:0] wr_addr = '0;
    logic [N_WR*DW-1:0] wr_data = '0;
    logic [N_WR-1:0]    wr_gnt;
    logic               mem_rd_en, mem_wr_en;
    logic [AW-1:0]      mem_rd_addr, mem_wr_addr;
    logic [DW-1:0]      mem_rd_word, mem_wr_word;
    logic [15:0]        coll_cnt;

    always #5 clk = ~clk;

    tp_mem_arbiter #(.AW(AW), .DW(DW), .N_RD(N_RD), .N_WR(N_WR), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_word(mem_rd_word),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_word(mem_wr_word),
        .coll_cnt(coll_cnt)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int a);
        return (a == 5) ? 64'hA5A5 : {32'hFACE_0000, 22'b0, 10'(a)};
    endfunction

    // Memory behind the arbiter: preloaded once, registered read
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] rpipe [RD_LAT];
    bit loaded = 0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int a = 0; a < 1024; a++) mem[a] <= init_word(a);
            loaded <= 1;
        end else if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_word;
        rpipe[0] <= mem_rd_en ? mem[mem_rd_addr] : '0;
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rd_word = rpipe[RD_LAT-1];

    // Reference model state
    logic [DW-1:0] ref_mem [int];
    int rd_nxt = 0, wr_nxt = 0, m_cnt = 0, cyc = 0;
    typedef struct { int cl; logic [DW-1:0] d; int due; } exp_t;
    exp_t sb [$];
    bit p_w = 0, p_r = 0, p_c = 0;
    int p_wk = 0, p_rc = 0;
    logic [AW-1:0] p_wa = '0;
    logic [DW-1:0] p_wd = '0;
    logic [N_RD-1:0] last_rd_gnt = '0;
    logic [N_WR-1:0] last_wr_gnt = '0;

    function automatic logic [DW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic int pick(input logic [3:0] req, input int nxt, input int n);
        for (int i = 0; i < n; i++) if (req[(nxt + i) % n]) return (nxt + i) % n;
        return -1;
    endfunction

    // Expected grants for this cycle; push expected read returns
    always @(negedge clk) begin
        int wk, rc, wi, ri;
        bit col;
        logic [AW-1:0] wa, ra;
        logic [N_WR-1:0] ew;
        logic [N_RD-1:0] er;
        wk = rst_n ? pick(4'(wr_req), wr_nxt, N_WR) : -1;
        rc = rst_n ? pick(4'(rd_req), rd_nxt, N_RD) : -1;
        wi = (wk < 0) ? 0 : wk;
        ri = (rc < 0) ? 0 : rc;
        wa = wr_addr[wi*AW +: AW];
        ra = rd_addr[ri*AW +: AW];
        col = (wk >= 0) && (rc >= 0) && (ra == wa);
        ew = (wk >= 0) ? (N_WR'(1) << wi) : '0;
        er = (rc >= 0 && !col) ? (N_RD'(1) << ri) : '0;
        chk("wr_gnt", wr_gnt, ew);
        chk("rd_gnt", rd_gnt, er);
        chk("mem_wr_en", mem_wr_en, wk >= 0);
        chk("mem_rd_en", mem_rd_en, |er);
        chk("coll_cnt", coll_cnt, m_cnt);
        if (wk >= 0) begin
            chk("mem_wr_addr", mem_wr_addr, wa);
            chk("mem_wr_word", mem_wr_word, wr_data[wi*DW +: DW]);
        end
        if (|er) begin
            chk("mem_rd_addr", mem_rd_addr, ra);
            sb.push_back('{ri, ref_rd(int'(ra)), cyc + RD_LAT});
        end
        p_w = wk >= 0; p_wk = wi; p_wa = wa; p_wd = wr_data[wi*DW +: DW];
        p_r = |er; p_rc = ri; p_c = col;
        last_rd_gnt = rd_gnt;
        last_wr_gnt = wr_gnt;
    end

    // Apply the cycle's effects at the edge; reset wipes everything in flight
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_nxt = 0; wr_nxt = 0; m_cnt = 0;
            sb.delete();
        end else begin
            cyc++;
            if (p_w) begin
                ref_mem[int'(p_wa)] = p_wd;
                wr_nxt = (p_wk + 1) % N_WR;
            end
            if (p_r) rd_nxt = (p_rc + 1) % N_RD;
            if (p_c && m_cnt < 65535) m_cnt++;
        end
    end

    // Monitor: every rd_vld pulse must match the oldest outstanding read
    always @(negedge clk) begin
        exp_t e;
        if (rd_vld != 0) begin
            if (sb.size() == 0) chk("rd_vld_unexpected", rd_vld, 0);
            else begin
                e = sb.pop_front();
                chk("rd_vld", rd_vld, N_RD'(1) << e.cl);
                chk("rd_data", rd_data, e.d);
                chk("rd_latency", cyc, e.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("rd_vld_missing", rd_vld, N_RD'(1) << e.cl);
        end
    end

    task automatic step();
        @(posedge clk); #1;
        rd_req &= ~last_rd_gnt;
        wr_req &= ~last_wr_gnt;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((rd_req != 0 || wr_req != 0) && n < lim) begin
            step();
            n++;
        end
        if (n >= lim) chk("idle_timeout", 64'(rd_req) | 64'(wr_req), 0);
        repeat (RD_LAT + 1) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, g1, a0, a1;
        logic [15:0] c0;
        // Reset with requests pending: nothing may be granted
        rst_n = 0; rd_req = '1; wr_req = '1;
        repeat (3) @(posedge clk);
        #1;
        rd_req = '0; wr_req = '0; rst_n = 1;
        step();

        // Single read of preloaded addr 5
        rd_req = 2'b01; rd_addr[0 +: AW] = 10'd5;
        @(negedge clk); #1;
        chk("t1_gnt", rd_gnt, 2'b01);
        step();
        @(negedge clk); #1;
        chk("t1_vld", rd_vld, 2'b01);
        chk("t1_data", rd_data, 64'hA5A5);
        step();

        // Read fairness: both clients requesting for 8 cycles
        g0 = 0; g1 = 0;
        rd_addr = {10'd21, 10'd20};
        for (int i = 0; i < 8; i++) begin
            rd_req = '1;
            @(negedge clk); #1;
            g0 += int'(rd_gnt[0]);
            g1 += int'(rd_gnt[1]);
            step();
        end
        rd_req = '0;
        chk("t2_fair_rd0", g0, 4);
        chk("t2_fair_rd1", g1, 4);
        repeat (3) step();

        // Write fairness then readback
        a0 = 1; a1 = 11; g0 = 0; g1 = 0;
        for (int i = 0; i < 8; i++) begin
            if (!wr_req[0] && a0 <= 4) begin
                wr_req[0] = 1; wr_addr[0 +: AW] = AW'(a0); wr_data[0 +: DW] = 64'hB000 + 64'(a0); a0++;
            end
            if (!wr_req[1] && a1 <= 14) begin
                wr_req[1] = 1; wr_addr[AW +: AW] = AW'(a1); wr_data[DW +: DW] = 64'hC000 + 64'(a1); a1++;
            end
            @(negedge clk); #1;
            g0 += int'(wr_gnt[0]);
            g1 += int'(wr_gnt[1]);
            step();
        end
        chk("t3_fair_wr0", g0, 4);
        chk("t3_fair_wr1", g1, 4);
        wait_idle(10);
        for (int i = 0; i < 4; i++) begin
            rd_req = '1;
            rd_addr = {AW'(11 + i), AW'(1 + i)};
            wait_idle(10);
        end

        // Collision: read of addr 7 while addr 7 is written
        c0 = coll_cnt;
        wr_req = 2'b01; wr_addr[0 +: AW] = 10'd7; wr_data[0 +: DW] = 64'h1234;
        rd_req = 2'b01; rd_addr[0 +: AW] = 10'd7;
        @(negedge clk); #1;
        chk("t4_rd_deferred", rd_gnt, 0);
        chk("t4_wr_gnt", wr_gnt, 2'b01);
        step();
        @(negedge clk); #1;
        chk("t4_coll_cnt", coll_cnt, c0 + 16'd1);
        chk("t4_rd_gnt_next", rd_gnt, 2'b01);
        step();
        @(negedge clk); #1;
        chk("t4_vld", rd_vld, 2'b01);
        chk("t4_data", rd_data, 64'h1234);
        step();

        // Non-colliding overlap
        c0 = coll_cnt;
        wr_req = 2'b01; wr_addr[0 +: AW] = 10'd9; wr_data[0 +: DW] = 64'h9999;
        rd_req = 2'b01; rd_addr[0 +: AW] = 10'd8;
        @(negedge clk); #1;
        chk("t5_rd_gnt", rd_gnt, 2'b01);
        chk("t5_wr_gnt", wr_gnt, 2'b01);
        step();
        @(negedge clk); #1;
        chk("t5_coll_cnt", coll_cnt, c0);
        wait_idle(5);

        // Randomized traffic over a small address range to provoke collisions
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N_RD; i++) begin
                if (!rd_req[i]) begin
                    if ($urandom_range(2) != 0) begin
                        rd_req[i] = 1; rd_addr[i*AW +: AW] = AW'($urandom_range(15));
                    end
                end else if ($urandom_range(9) == 0) rd_req[i] = 0;
            end
            for (int i = 0; i < N_WR; i++) begin
                if (!wr_req[i]) begin
                    if ($urandom_range(2) != 0) begin
                        wr_req[i] = 1; wr_addr[i*AW +: AW] = AW'($urandom_range(15));
                        wr_data[i*DW +: DW] = {$urandom, $urandom};
                    end
                end else if ($urandom_range(9) == 0) wr_req[i] = 0;
            end
            step();
        end
        rd_req = '0; wr_req = '0;
        repeat (3) step();

        // Reset while a read is in flight; rd_ptr is 1 beforehand
        rd_req = 2'b01; rd_addr[0 +: AW] = 10'd3;
        wait_idle(5);
        rd_req = 2'b10; rd_addr[AW +: AW] = 10'd4;
        @(negedge clk); #1;
        rst_n = 0; rd_req = '0; wr_req = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        chk("t6_coll_after_reset", coll_cnt, 0);
        rd_req = 2'b11; rd_addr = {10'd31, 10'd30};
        @(negedge clk); #1;
        chk("t6_first_gnt", rd_gnt, 2'b01);
        step();
        wait_idle(5);

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tp_mem_arbiter.md
Name: tp_mem_arbiter

Overview:
- Round-robin access arbiter placed in front of one two-port 1024x64 user memory (separate read and write ports).
- Shares the read port among N_RD requesters and the write port among N_WR requesters.
- Resolves same-cycle read/write address collisions.
- Tracks each read in flight and returns data with a per-client valid strobe, RD_LAT cycles after the grant.

Parameters:
- AW, 10, address width (1024 words)
- DW, 64, data width
- N_RD, 2, number of read clients (2..4)
- N_WR, 2, number of write clients (2..4)
- RD_LAT, 1, memory read latency in cycles, grant to data (1..3)

Ports:
- clk  in  1  clock
- rst_n  in  1  async reset, active low
- rd_req  in  N_RD  per-client read request, held until granted
- rd_addr  in  N_RD*AW  per-client read address, client i at slice [i*AW +: AW]
- rd_gnt  out  N_RD  one-hot read grant, same cycle as the request
- rd_vld  out  N_RD  one-hot strobe: rd_data belongs to this client
- rd_data  out  DW  read data, shared by all clients
- wr_req  in  N_WR  per-client write request, held until granted
- wr_addr  in  N_WR*AW  per-client write address
- wr_data  in  N_WR*DW  per-client write data
- wr_gnt  out  N_WR  one-hot write grant
- mem_rd_en  out  1  memory read enable, active high
- mem_rd_addr  out  AW  memory read address
- mem_rd_word  in  DW  memory read data, valid RD_LAT cycles after mem_rd_en
- mem_wr_en  out  1  memory write enable, active high
- mem_wr_addr  out  AW  memory write address
- mem_wr_word  out  DW  memory write data
- coll_cnt  out  16  count of read grants deferred by a collision, saturating

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd_ptr, wr_ptr = 0; return pipeline cleared; coll_cnt = 0.
  - While rst_n is low, rd_gnt, wr_gnt, rd_vld, mem_rd_en and mem_wr_en are forced to 0. Addresses and data outputs are don't-care.
- Write arbitration (combinational from registered wr_ptr):
  - Search clients wr_ptr, wr_ptr+1, ... mod N_WR; the first with wr_req set wins.
  - wr_gnt[k]=1; mem_wr_en=1; mem_wr_addr/word = client k slices.
  - At the clock edge, wr_ptr <= (k+1) mod N_WR. If no request, wr_ptr holds.
- Read arbitration: same round-robin scheme with rd_ptr, giving candidate c.
- Collision rule:
  - If a write is granted this cycle and candidate c's address equals mem_wr_addr, client c is not granted.
  - The arbiter does not try another client; rd_gnt = 0 and mem_rd_en = 0 that cycle.
  - rd_ptr holds, so c wins next cycle.
  - coll_cnt increments by 1, saturating at 16'hFFFF.
  - Net effect: a read never overlaps a write to the same address, and the read returns the new data.
- Read grant: rd_gnt[c]=1; mem_rd_en=1; mem_rd_addr=c's address; at the clock edge, rd_ptr <= (c+1) mod N_RD.
- Return pipeline:
  - RD_LAT-deep shift register of {valid, client id}, loaded each cycle from the read grant.
  - At its output, rd_vld[id]=valid; rd_data = mem_rd_word, passed through combinationally.
  - Back-to-back grants give back-to-back rd_vld pulses, one per cycle, in grant order.
- Throughput: one read plus one write per cycle. Requesters see no backpressure beyond the grant.
- Fairness:
  - With all clients continuously requesting, each is granted once every N cycles on its port.
  - A waiting client is granted within N_RD cycles (read), or N_WR cycles (write), plus any collision deferrals.
- Requester contract:
  - req, addr and data stay stable until the cycle gnt is seen.
  - Deasserting a request before its grant is legal; that client is simply skipped.
- Reset mid-operation: in-flight reads are dropped; no rd_vld is issued after reset is released.

Decomposition:
- Package tp_mem_arb_pkg holds:
  - localparams AW and DW;
  - client-id width function clog2(N);
  - a typedef for the return-pipeline entry {logic vld; logic [IDW-1:0] id}.
- One natural sub-module, rr_arbiter (parameter N), instantiated twice, once for reads and once for writes:
  - inputs: req, ptr, mask enable;
  - outputs: one-hot gnt, encoded index, any.
- The top level holds the pointers, the collision compare, the return pipeline and the counter.

Test Plan:
1. Single read, RD_LAT=1:
   - Stimulus: memory preloaded with addr 5 = 64'hA5A5; client 0 requests addr 5.
   - Response: rd_gnt=01 in cycle t; rd_vld=01 with rd_data=64'hA5A5 at t+1.
2. Read fairness:
   - Stimulus: both read clients request continuously for 8 cycles.
   - Response: rd_gnt alternates 01,10,01,... with 4 grants each; rd_vld follows with the same order, 1 cycle later.
3. Write fairness:
   - Stimulus: both write clients request continuously; wr0 writes addr 1..4, wr1 writes addr 11..14.
   - Response: grants alternate; readback of addr 1..4 and 11..14 returns the written data.
4. Collision:
   - Stimulus: wr0 writes 64'h1234 to addr 7 while rd0 requests addr 7 in the same cycle.
   - Response: rd_gnt=0 that cycle and coll_cnt=1; rd_gnt=01 next cycle; rd_data=64'h1234.
5. Non-colliding overlap: read of addr 8 together with write of addr 9 -> both granted in the same cycle; coll_cnt unchanged.
6. Reset mid-flight:
   - Stimulus: grant a read at t, assert rst_n low at t+0.5.
   - Response: rd_vld stays 0; pointers are 0 and coll_cnt is 0 after release; the first grant after release goes to client 0 when both clients request.
